// File: rtl/da_drv_gen.sv
// da_drv_gen: time-multiplexed dual-DAC driver.
// Each of NBUS shared data buses serves four channels in four sub-slots of
// SLOT_CYC clocks; a per-channel active-low strobe is pulsed inside each
// sub-slot with one cycle of setup and one cycle of hold.
// A one-frame shadow register decouples the upstream handshake from the
// running frame, so a new frame can be queued without tearing the current one.
// Optional feature macro: DA_DRV_REFRESH_EN. When defined, the working frame is
// resent back-to-back whenever no new frame is waiting at frame end.
// SLOT_CYC must be 3 or more (setup + at least one strobe cycle + hold).
module da_drv_gen #(
  parameter int DW       = 10,
  parameter int NBUS     = 4,
  parameter int SLOT_CYC = 3
) (
  input  logic                   Clk1,
  input  logic                   aRst,
  input  logic [4*NBUS*DW-1:0]   InData,
  input  logic                   InVld,
  output logic                   InRdy,
  output logic [NBUS*DW-1:0]     DaData,
  output logic [4*NBUS-1:0]      DaCs_n,
  output logic                   FrameDone,
  output logic                   Busy
);

  localparam int CW   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int HOLD = 16;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
  // [bus][sub-slot][bit]: element [b][s] sits at bits (4b+s)*DW, i.e. channel 4b+s
  typedef logic [NBUS-1:0][3:0][DW-1:0] frame_t;

  state_e        state_q, state_d;
  logic [1:0]    sub_q, sub_d;
  logic [CW-1:0] cyc_q, cyc_d;
  frame_t        shad_q, shad_d;
  frame_t        work_q, work_d;
  logic          shad_full_q, shad_full_d;
  logic [4:0]    hold_q, hold_d;
  logic          rdy_q, rdy_d;
  logic          xfer;
  logic          accept;

  logic [NBUS-1:0][DW-1:0] da_q;
  logic [4*NBUS-1:0]       cs_n_q;
  logic                    done_q, busy_q;
  logic                    strobe;

  assign accept = InVld & rdy_q;
  // strobe window excludes the first (setup) and last (hold) slot cycle
  assign strobe = (cyc_q != '0) && (cyc_q != LAST);

  // Sequencer next state: slot/sub-slot stepping and working-register loads
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cyc_d   = cyc_q;
    work_d  = work_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: if (shad_full_q) state_d = LOAD;
      LOAD: begin
        xfer    = 1'b1;
        work_d  = shad_q;
        sub_d   = 2'd0;
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cyc_q == LAST) begin
          cyc_d = '0;
          sub_d = sub_q + 2'd1;
          if (sub_q == 2'd3) begin
            if (shad_full_q) begin
              // next frame waiting: swap it in with no gap cycle
              xfer   = 1'b1;
              work_d = shad_q;
            end else begin
`ifdef DA_DRV_REFRESH_EN
              state_d = RUN;
`else
              state_d = IDLE;
`endif
            end
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow register and ready: a same-edge accept wins over the transfer clear
  always_comb begin
    shad_d      = shad_q;
    shad_full_d = shad_full_q;
    if (xfer) shad_full_d = 1'b0;
    if (accept) begin
      shad_d      = InData;
      shad_full_d = 1'b1;
    end
    hold_d = (hold_q == 5'(HOLD)) ? hold_q : hold_q + 5'd1;
    rdy_d  = (hold_d == 5'(HOLD)) && !shad_full_d;
  end

  // Control and data state registers
  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      state_q     <= IDLE;
      sub_q       <= 2'd0;
      cyc_q       <= '0;
      shad_q      <= '0;
      work_q      <= '0;
      shad_full_q <= 1'b0;
      hold_q      <= 5'd0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      cyc_q       <= cyc_d;
      shad_q      <= shad_d;
      work_q      <= work_d;
      shad_full_q <= shad_full_d;
      hold_q      <= hold_d;
      rdy_q       <= rdy_d;
    end
  end

  // Output registers: one cycle behind the slot counter
  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      da_q   <= '0;
      cs_n_q <= '1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cs_n_q <= '1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      if (state_q == RUN) begin
        busy_q <= 1'b1;
        done_q <= (sub_q == 2'd3) && (cyc_q == LAST);
        for (int b = 0; b < NBUS; b++) begin
          da_q[b] <= work_q[b][sub_q];
          if (strobe) cs_n_q[4*b +: 4] <= ~(4'b0001 << sub_q);
        end
      end
    end
  end

  assign InRdy     = rdy_q;
  assign DaData    = da_q;
  assign DaCs_n    = cs_n_q;
  assign FrameDone = done_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_da_drv_gen.sv
// tb_da_drv_gen: self-checking bench for da_drv_gen (DW=10, NBUS=4, SLOT_CYC=3).
// Expected outputs come from a frame schedule: acceptance and start edges are
// computed per frame from the handshake, latency and frame-boundary rules, and
// every output cycle is derived from which frame (if any) is on the buses.
module tb_da_drv_gen;
  localparam int DW   = 10;
  localparam int NBUS = 4;
  localparam int SC   = 3;
  localparam int NCH  = 4 * NBUS;
  localparam int FLEN = 4 * SC;
  localparam int HOLD = 16;

  logic              Clk1 = 1'b0;
  logic              aRst = 1'b1;
  logic [NCH*DW-1:0] InData = '0;
  logic              InVld = 1'b0;
  logic              InRdy;
  logic [NBUS*DW-1:0] DaData;
  logic [NCH-1:0]    DaCs_n;
  logic              FrameDone;
  logic              Busy;

  da_drv_gen #(.DW(DW), .NBUS(NBUS), .SLOT_CYC(SC)) dut (
    .Clk1(Clk1), .aRst(aRst), .InData(InData), .InVld(InVld), .InRdy(InRdy),
    .DaData(DaData), .DaCs_n(DaCs_n), .FrameDone(FrameDone), .Busy(Busy)
  );

  always #5 Clk1 = ~Clk1;

  int errs   = 0;
  int checks = 0;

  // schedule: frames, issue edge, acceptance edge, first output cycle
  logic [NCH*DW-1:0] fr [8];
  int gap [8];
  int iss [8];
  int acc [8];
  int st  [8];
  int nf;
  int iss0;

  function automatic logic [DW-1:0] ch(input logic [NCH*DW-1:0] f, input int c);
    return f[c*DW +: DW];
  endfunction

  function automatic logic [NCH*DW-1:0] rnd_frame();
    logic [NCH*DW-1:0] f;
    for (int c = 0; c < NCH; c++) f[c*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  // Edge t is the t-th rising edge after reset release; "cycle t" follows it.
  // Ready is high from cycle HOLD on except while a frame sits in the shadow
  // (from its acceptance edge until the edge before it starts on the buses).
  task automatic plan();
    int a, b;
    for (int n = 0; n < nf; n++) begin
      iss[n] = (n == 0) ? iss0 : acc[n-1] + 1 + gap[n];
      a = (iss[n] < HOLD + 1) ? HOLD + 1 : iss[n];
      if (n > 0 && a < st[n-1]) a = st[n-1];
      acc[n] = a;
      if (n == 0) st[n] = a + 3;
      else begin
`ifdef DA_DRV_REFRESH_EN
        b = st[n-1] + FLEN;
        while (a > b - 2) b += FLEN;
        st[n] = b;
`else
        b = 0;
        st[n] = (a <= st[n-1] + FLEN - 2) ? st[n-1] + FLEN : a + 3;
`endif
      end
    end
  endtask

  task automatic apply_reset(input string name);
    aRst  = 1'b1;
    InVld = 1'b0;
    repeat (2) @(posedge Clk1);
    #1;
    checks++; if (DaCs_n !== '1)  begin errs++; $display("FAIL %s DaCs_n got %h want ffff", name, DaCs_n); end
    checks++; if (DaData !== '0)  begin errs++; $display("FAIL %s DaData got %h want 0", name, DaData); end
    checks++; if (InRdy !== 1'b0) begin errs++; $display("FAIL %s InRdy got %b want 0", name, InRdy); end
    checks++; if (Busy !== 1'b0)  begin errs++; $display("FAIL %s Busy got %b want 0", name, Busy); end
    checks++; if (FrameDone !== 1'b0) begin errs++; $display("FAIL %s FrameDone got %b want 0", name, FrameDone); end
  endtask

  // Releases reset, drives the planned frames and compares every cycle.
  // abort_rel >= 0 re-asserts reset at cycle st[0]+abort_rel.
  task automatic run_sched(input string name, input int abort_rel);
    int t, tend, n, i, sub, cyc, abort_t;
    logic [NBUS*DW-1:0] eda;
    logic [NCH-1:0]     ecs;
    logic               edone, ebusy, erdy, act;
    plan();
    tend    = st[nf-1] + 3 * FLEN;
    abort_t = (abort_rel >= 0) ? st[0] + abort_rel : -1;
    @(negedge Clk1);
    aRst = 1'b0;
    t = 0;
    while (t <= tend) begin
      n = -1;
      for (int k = 0; k < nf; k++) if (st[k] <= t) n = k;
      act = 1'b0; i = 0;
      if (n >= 0) begin
`ifdef DA_DRV_REFRESH_EN
        act = 1'b1; i = (t - st[n]) % FLEN;
`else
        if (t < st[n] + FLEN) begin act = 1'b1; i = t - st[n]; end
`endif
      end
      ecs = '1; edone = 1'b0; ebusy = 1'b0; eda = '0;
      if (act) begin
        sub = i / SC; cyc = i % SC;
        ebusy = 1'b1;
        edone = (i == FLEN - 1);
        for (int b = 0; b < NBUS; b++) begin
          eda[b*DW +: DW] = ch(fr[n], 4*b + sub);
          if (cyc >= 1 && cyc <= SC - 2) ecs[4*b + sub] = 1'b0;
        end
      end else if (n >= 0) begin
        for (int b = 0; b < NBUS; b++) eda[b*DW +: DW] = ch(fr[n], 4*b + 3);
      end
      erdy = (t >= HOLD);
      for (int k = 0; k < nf; k++) if (acc[k] <= t && t <= st[k] - 2) erdy = 1'b0;

      checks++; if (DaData !== eda)  begin errs++; $display("FAIL %s t=%0d DaData got %h want %h", name, t, DaData, eda); end
      checks++; if (DaCs_n !== ecs)  begin errs++; $display("FAIL %s t=%0d DaCs_n got %h want %h", name, t, DaCs_n, ecs); end
      checks++; if (FrameDone !== edone) begin errs++; $display("FAIL %s t=%0d FrameDone got %b want %b", name, t, FrameDone, edone); end
      checks++; if (Busy !== ebusy)  begin errs++; $display("FAIL %s t=%0d Busy got %b want %b", name, t, Busy, ebusy); end
      checks++; if (InRdy !== erdy)  begin errs++; $display("FAIL %s t=%0d InRdy got %b want %b", name, t, InRdy, erdy); end

      if (t == abort_t) begin
        InVld = 1'b0;
        aRst  = 1'b1;
        #1;
        checks++; if (DaCs_n !== '1)  begin errs++; $display("FAIL %s abort DaCs_n got %h want ffff", name, DaCs_n); end
        checks++; if (DaData !== '0)  begin errs++; $display("FAIL %s abort DaData got %h want 0", name, DaData); end
        checks++; if (InRdy !== 1'b0) begin errs++; $display("FAIL %s abort InRdy got %b want 0", name, InRdy); end
        checks++; if (Busy !== 1'b0)  begin errs++; $display("FAIL %s abort Busy got %b want 0", name, Busy); end
        checks++; if (FrameDone !== 1'b0) begin errs++; $display("FAIL %s abort FrameDone got %b want 0", name, FrameDone); end
        return;
      end

      // inputs for edge t+1: a frame is offered from its issue edge until taken
      InVld  = 1'b0;
      InData = rnd_frame();
      for (int k = 0; k < nf; k++)
        if (iss[k] <= t + 1 && t + 1 <= acc[k]) begin InVld = 1'b1; InData = fr[k]; end
      @(posedge Clk1);
      #1;
      t++;
    end
    InVld = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  // frame with channel c = c+1, InVld held high through the reset hold-off
  task automatic test_single_frame();
    apply_reset("single_rst");
    nf = 1; iss0 = 0;
    for (int c = 0; c < NCH; c++) fr[0][c*DW +: DW] = DW'(c + 1);
    run_sched("single", -1);
  endtask

  // three frames offered back-to-back; the third waits on a full shadow
  task automatic test_back_to_back();
    apply_reset("b2b_rst");
    nf = 3; iss0 = 20;
    for (int n = 0; n < nf; n++) begin fr[n] = rnd_frame(); gap[n] = 0; end
    run_sched("b2b", -1);
  endtask

  // second frame lands just in time for a seamless swap, third just too late
  task automatic test_boundary();
    apply_reset("bound_rst");
    nf = 3; iss0 = int'($urandom_range(0, 10));
    for (int n = 0; n < nf; n++) fr[n] = rnd_frame();
    gap[1] = 12; gap[2] = 12;
    run_sched("boundary", -1);
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 3; r++) begin
      apply_reset("rand_rst");
      nf = 5; iss0 = int'($urandom_range(0, 30));
      for (int n = 0; n < nf; n++) begin fr[n] = rnd_frame(); gap[n] = int'($urandom_range(0, 20)); end
      run_sched("random", -1);
    end
  endtask

  // reset hits inside sub-slot 2 with a strobe low, then a clean restart
  task automatic test_reset_mid_frame();
    apply_reset("mid_rst");
    nf = 1; iss0 = 18;
    fr[0] = rnd_frame();
    run_sched("mid_abort", 7);
    iss0 = 0;
    fr[0] = rnd_frame();
    run_sched("mid_restart", -1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_boundary();
    test_random_frames();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
